trng_sample_ctrl: RTL and testbench

Sequencing controller for the 4-output ring-oscillator bank of the TRNG.
- Synchronises the RO outputs, runs a warm-up period, then decimates and XOR-combines the RO pairs into one raw bit per sample tick.
- Packs the raw bits into WORD_W-bit random words and hands them out over a valid/ready interface.
- Sits between the RO bank and the SE-QUBIP entropy consumers (DRBG seeding, key generation).

---
 rtl/trng_pkg.sv | 28 ++
 rtl/trng_sync2.sv | 27 ++
 rtl/trng_sample_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_trng_sample_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG sample controller (trng_sample_ctrl, trng_sync2).
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COLLECT = 2'd2,
    ST_OUTPUT  = 2'd3
  } trng_state_e;

  localparam int TRNG_WORD_W     = 64;
  localparam int TRNG_WARMUP     = 256;
  localparam int TRNG_SAMPLE_DIV = 4;
  localparam int TRNG_REP_LIMIT  = 32;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) <= max_val) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/trng_sync2.sv
// Two-flop synchroniser for asynchronous inputs, synchronous active-high reset.
module trng_sync2 #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Metastability filter: first flop may go metastable, second resolves it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= {W{1'b0}};
      r_sync <= {W{1'b0}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/trng_sample_ctrl.sv
// Ring-oscillator sampling controller: warm-up, decimated XOR sampling, word packing, valid/ready hand-off.
// Optional repetition-count health test enabled by defining TRNG_CTRL_HEALTH_EN.
module trng_sample_ctrl
  import trng_pkg::*;
#(
  parameter int WORD_W     = TRNG_WORD_W,
  parameter int WARMUP_CYC = TRNG_WARMUP,
  parameter int SAMPLE_DIV = TRNG_SAMPLE_DIV,
  parameter int REP_LIMIT  = TRNG_REP_LIMIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_ro,
  input  logic              i_enable,
  input  logic              i_out_ready,
  output logic [WORD_W-1:0] o_out_data,
  output logic              o_out_valid,
  output logic              o_busy,
  output logic              o_health_err
);

  localparam int WU_W  = cnt_w(WARMUP_CYC - 1);
  localparam int DIV_W = cnt_w(SAMPLE_DIV - 1);
  localparam int BIT_W = cnt_w(WORD_W - 1);

  if (WORD_W < 8 || WORD_W > 256) begin : g_bad_word_w
    $error("trng_sample_ctrl: WORD_W must be 8..256");
  end
  if (WARMUP_CYC < 1 || SAMPLE_DIV < 1) begin : g_bad_timing
    $error("trng_sample_ctrl: WARMUP_CYC and SAMPLE_DIV must be >= 1");
  end
  if (REP_LIMIT < 2) begin : g_bad_rep
    $error("trng_sample_ctrl: REP_LIMIT must be >= 2");
  end

  trng_state_e       r_state;
  trng_state_e       w_state_nxt;
  logic [WU_W-1:0]   r_wu_cnt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] w_shift_nxt;
  logic [WORD_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_busy;
  logic [3:0]        w_ro_s;
  logic              w_rb;
  logic              w_tick;
  logic              w_word_done;
  logic              w_rep_trip;
  logic              w_run_ok;

  trng_sync2 #(.W(4)) u_ro_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_ro),
    .o_q   (w_ro_s)
  );

  assign w_rb        = (w_ro_s[0] ^ w_ro_s[1]) ^ (w_ro_s[2] ^ w_ro_s[3]);
  assign w_tick      = (r_state == ST_COLLECT) && (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign w_word_done = w_tick && (r_bit_cnt == BIT_W'(WORD_W - 1));
  assign w_shift_nxt = {r_shift[WORD_W-2:0], w_rb};

`ifdef TRNG_CTRL_HEALTH_EN
  localparam int REP_W = cnt_w(REP_LIMIT);

  logic [REP_W-1:0] r_rep_cnt;
  logic [REP_W-1:0] w_rep_nxt;
  logic             r_last_rb;
  logic             r_health_err;

  // Run length including the current bit; a zero count means no bit seen since entering COLLECT.
  always_comb begin
    w_rep_nxt = {{(REP_W-1){1'b0}}, 1'b1};
    if ((r_rep_cnt != {REP_W{1'b0}}) && (w_rb == r_last_rb)) begin
      w_rep_nxt = r_rep_cnt + REP_W'(1);
    end else begin
      w_rep_nxt = {{(REP_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_rep_trip = w_tick && (w_rep_nxt == REP_W'(REP_LIMIT));
  assign w_run_ok   = i_enable && !r_health_err;

  // Repetition-count state and the sticky failure flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rep_cnt    <= {REP_W{1'b0}};
      r_last_rb    <= 1'b0;
      r_health_err <= 1'b0;
    end else begin
      if (r_state != ST_COLLECT) begin
        r_rep_cnt <= {REP_W{1'b0}};
      end else if (w_tick) begin
        r_rep_cnt <= w_rep_nxt;
        r_last_rb <= w_rb;
      end else begin
        r_rep_cnt <= r_rep_cnt;
      end
      r_health_err <= r_health_err | w_rep_trip;
    end
  end

  assign o_health_err = r_health_err;
`else
  assign w_rep_trip   = 1'b0;
  assign w_run_ok     = i_enable;
  assign o_health_err = 1'b0;
`endif

  // Next-state logic; enable low wins over everything, including a pending handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_run_ok) begin
          w_state_nxt = ST_WARMUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (!i_enable) begin
          w_state_nxt = ST_IDLE;
        end else if (r_wu_cnt == {WU_W{1'b0}}) begin
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = ST_WARMUP;
        end
      end
      ST_COLLECT: begin
        if (!i_enable || w_rep_trip) begin
          w_state_nxt = ST_IDLE;
        end else if (w_word_done) begin
          w_state_nxt = ST_OUTPUT;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_OUTPUT: begin
        if (!i_enable) begin
          w_state_nxt = ST_IDLE;
        end else if (i_out_ready) begin
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = ST_OUTPUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, shift register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wu_cnt    <= {WU_W{1'b0}};
      r_div_cnt   <= {DIV_W{1'b0}};
      r_bit_cnt   <= {BIT_W{1'b0}};
      r_shift     <= {WORD_W{1'b0}};
      r_out_data  <= {WORD_W{1'b0}};
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_state_nxt == ST_WARMUP) begin
        r_wu_cnt <= WU_W'(WARMUP_CYC - 1);
      end else if (r_state == ST_WARMUP && r_wu_cnt != {WU_W{1'b0}}) begin
        r_wu_cnt <= r_wu_cnt - WU_W'(1);
      end else begin
        r_wu_cnt <= {WU_W{1'b0}};
      end

      // Counters only advance while staying in COLLECT, so every entry starts from zero.
      if (r_state == ST_COLLECT && w_state_nxt == ST_COLLECT) begin
        if (w_tick) begin
          r_div_cnt <= {DIV_W{1'b0}};
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
          r_bit_cnt <= r_bit_cnt;
        end
      end else begin
        r_div_cnt <= {DIV_W{1'b0}};
        r_bit_cnt <= {BIT_W{1'b0}};
      end

      if (w_state_nxt == ST_IDLE) begin
        r_shift <= {WORD_W{1'b0}};
      end else if (w_tick) begin
        r_shift <= w_shift_nxt;
      end else begin
        r_shift <= r_shift;
      end

      if (r_state == ST_COLLECT && w_state_nxt == ST_OUTPUT) begin
        r_out_data <= w_shift_nxt;
      end else begin
        r_out_data <= r_out_data;
      end

      r_out_valid <= (w_state_nxt == ST_OUTPUT);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed bench for trng_sample_ctrl (WORD_W=8, WARMUP_CYC=4, SAMPLE_DIV=2, REP_LIMIT=4).
module tb_trng_sample_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] ro;
  logic       enable;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       health_err;

  int vectors;
  int miscompares;

  logic [3:0] ro_one  [4];
  logic [3:0] ro_zero [4];

  trng_sample_ctrl #(
    .WORD_W     (8),
    .WARMUP_CYC (4),
    .SAMPLE_DIV (2),
    .REP_LIMIT  (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ro        (ro),
    .i_enable    (enable),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .o_busy      (busy),
    .o_health_err(health_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Hold each bit (MSB first) for two cycles, aligned so the sample tick two cycles later sees it.
  task automatic feed_bits(input logic [7:0] bits);
    for (int j = 7; j >= 0; j--) begin
      ro = bits[j] ? ro_one[j % 4] : ro_zero[j % 4];
      cyc1();
      chk("valid_low_collect", {63'd0, out_valid}, 64'd0);
      cyc1();
      chk("valid_low_collect", {63'd0, out_valid}, 64'd0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ro_one      = '{4'b0001, 4'b0111, 4'b1000, 4'b1011};
    ro_zero     = '{4'b0000, 4'b1111, 4'b0110, 4'b1001};
    rst         = 1'b1;
    enable      = 1'b0;
    out_ready   = 1'b0;
    ro          = 4'b0000;

    repeat (3) cyc1();
    chk("rst_data",   {56'd0, out_data},   64'd0);
    chk("rst_valid",  {63'd0, out_valid},  64'd0);
    chk("rst_busy",   {63'd0, busy},       64'd0);
    chk("rst_health", {63'd0, health_err}, 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc1();
      chk("idle_busy", {63'd0, busy}, 64'd0);
    end

    // Word 1: enable at cycle 0, valid exactly at cycle 21 with B2.
    enable    = 1'b1;
    out_ready = 1'b1;
    cyc1();
    chk("warmup_busy", {63'd0, busy}, 64'd1);
    repeat (3) cyc1();
    feed_bits(8'hB2);
    cyc1();
    chk("w1_valid", {63'd0, out_valid}, 64'd1);
    chk("w1_data",  {56'd0, out_data},  64'hB2);

    // Word 2 follows the handshake by 17 cycles, then is held under backpressure.
    feed_bits(8'h5C);
    out_ready = 1'b0;
    cyc1();
    chk("w2_valid", {63'd0, out_valid}, 64'd1);
    chk("w2_data",  {56'd0, out_data},  64'h5C);
    for (int k = 0; k < 10; k++) begin
      ro = 4'($urandom_range(15, 0));
      cyc1();
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_data",  {56'd0, out_data},  64'h5C);
    end
    out_ready = 1'b1;
    feed_bits(8'h3A);
    cyc1();
    chk("w3_valid", {63'd0, out_valid}, 64'd1);
    chk("w3_data",  {56'd0, out_data},  64'h3A);

    // Abort after five bits of the next word.
    for (int k = 0; k < 5; k++) begin
      ro = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      cyc1();
      cyc1();
    end
    enable = 1'b0;
    cyc1();
    chk("abort_busy",  {63'd0, busy},      64'd0);
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    repeat (3) cyc1();
    chk("abort_idle", {63'd0, busy}, 64'd0);

    // Re-enable: full warm-up again, word valid 21 cycles later.
    enable    = 1'b1;
    out_ready = 1'b0;
    ro        = 4'b1110;
    cyc1();
    chk("rewarm_busy", {63'd0, busy}, 64'd1);
    repeat (3) cyc1();
    feed_bits(8'h4D);
    cyc1();
    chk("w4_valid", {63'd0, out_valid}, 64'd1);
    chk("w4_data",  {56'd0, out_data},  64'h4D);
    cyc1();
    chk("w4_hold", {63'd0, out_valid}, 64'd1);

    // Enable low and ready high together: word discarded, back to IDLE.
    enable    = 1'b0;
    out_ready = 1'b1;
    cyc1();
    chk("coll_valid", {63'd0, out_valid}, 64'd0);
    chk("coll_busy",  {63'd0, busy},      64'd0);

    // Reset mid-operation clears everything, including the last word.
    enable = 1'b1;
    repeat (6) cyc1();
    chk("midrst_pre_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    cyc1();
    chk("midrst_busy",  {63'd0, busy},      64'd0);
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_data",  {56'd0, out_data},  64'd0);
    rst    = 1'b0;
    enable = 1'b0;
    cyc1();

`ifdef TRNG_CTRL_HEALTH_EN
    // Constant zero stream trips the test on the fourth tick (cycle 12), visible at cycle 13.
    enable = 1'b1;
    ro     = 4'b0000;
    repeat (12) cyc1();
    chk("health_pre", {63'd0, health_err}, 64'd0);
    chk("health_pre_busy", {63'd0, busy}, 64'd1);
    cyc1();
    chk("health_err",  {63'd0, health_err}, 64'd1);
    chk("health_busy", {63'd0, busy},       64'd0);
    repeat (3) cyc1();
    chk("health_novalid", {63'd0, out_valid}, 64'd0);
    enable = 1'b0;
    cyc1();
    enable = 1'b1;
    repeat (3) begin
      cyc1();
      chk("health_lock_busy", {63'd0, busy}, 64'd0);
    end
    chk("health_sticky", {63'd0, health_err}, 64'd1);
    rst = 1'b1;
    cyc1();
    chk("health_rst", {63'd0, health_err}, 64'd0);
    rst    = 1'b0;
    enable = 1'b0;
    cyc1();
`else
    // Without the health test a constant stream simply yields a zero word.
    enable    = 1'b1;
    out_ready = 1'b1;
    ro        = 4'b0000;
    repeat (4) cyc1();
    feed_bits(8'h00);
    cyc1();
    chk("zero_valid",  {63'd0, out_valid},  64'd1);
    chk("zero_data",   {56'd0, out_data},   64'd0);
    chk("zero_health", {63'd0, health_err}, 64'd0);
    enable = 1'b0;
    cyc1();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
